// File: rtl/act_buffer_reader.sv
// Read-side sequencer for the ping/pong activation buffer: issues buffer reads,
// tracks them through the fixed-latency read pipe and re-times data into a valid/ready stream.
module act_buffer_reader #(
  parameter int TM         = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH:0]           k_len,
  input  logic [1:0]                    bank_ready,
  output logic [1:0]                    bank_release,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         k_idx,
  output logic                          bank_sel_rd,
  input  logic [TM*8-1:0]               a_vec,
  output logic [TM*8-1:0]               a_out_data,
  output logic                          a_out_valid,
  input  logic                          a_out_ready,
  output logic                          a_out_last,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

  // Output stream handshake: a vector moves on a cycle where a_out_valid and
  // a_out_ready are both 1; valid never drops and data never changes until then.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BANK = 3'd1,
    S_STREAM    = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH:0]     r_len;
  logic [ADDR_WIDTH:0]     r_issued;
  logic [ADDR_WIDTH:0]     r_pushed;
  logic [ADDR_WIDTH-1:0]   r_last_idx;
  logic                    r_cur_bank;
  logic                    r_busy;
  logic                    r_done;
  logic [1:0]              r_release;
  logic [READ_LAT-1:0]     r_tag;
  logic [TM*8-1:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   r_mem_last;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic [CW-1:0]           w_inflight;
  logic [CW:0]             w_occ;
  logic                    w_issue;
  logic                    w_rd_en;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_start;
  logic [ADDR_WIDTH:0]     w_len;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_tag[i]);
    end
  end

  // Reserve FIFO space for every real read still in the buffer pipe so a push never overflows.
  assign w_occ   = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_issue = (r_state == S_STREAM) && (r_issued < r_len) &&
                   (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_rd_en = w_issue | (|r_tag);
  assign w_push  = w_rd_en & r_tag[READ_LAT-1];
  assign w_pop   = (r_count != '0) & a_out_ready;
  assign w_start = start & (r_state == S_IDLE) & ~r_busy & ~r_done;
  assign w_len   = (k_len > MAX_LEN) ? MAX_LEN : k_len;

  // Tag pipe mirrors the buffer read pipe, advancing only when the buffer does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else if (w_rd_en) begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < READ_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_mem_last <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pushed   <= '0;
    end else begin
      if (w_start) begin
        r_pushed <= '0;
      end else if (w_push) begin
        r_pushed <= r_pushed + (ADDR_WIDTH+1)'(1);
      end
      if (w_push) begin
        r_mem[r_wr_ptr]      <= a_vec;
        r_mem_last[r_wr_ptr] <= (r_pushed == r_len - (ADDR_WIDTH+1)'(1));
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_last_idx <= '0;
      r_cur_bank <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_release  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_release <= '0;
      if (w_issue) begin
        r_issued   <= r_issued + (ADDR_WIDTH+1)'(1);
        r_last_idx <= r_issued[ADDR_WIDTH-1:0];
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len    <= w_len;
            r_issued <= '0;
            r_busy   <= 1'b1;
            r_state  <= (w_len == '0) ? S_DONE : S_WAIT_BANK;
          end
        end
        S_WAIT_BANK: begin
          if (bank_ready[r_cur_bank]) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_issued == r_len) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_tag == '0) && (r_count == '0)) begin
            r_release[r_cur_bank] <= 1'b1;
            r_cur_bank            <= ~r_cur_bank;
            r_state               <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Dummy reads (tag flush only) repeat the last real address on the held bank.
  assign rd_en          = w_rd_en;
  assign k_idx          = w_issue ? r_issued[ADDR_WIDTH-1:0] : r_last_idx;
  assign bank_sel_rd    = r_cur_bank;
  assign bank_release   = r_release;
  assign a_out_valid    = (r_count != '0);
  assign a_out_data     = r_mem[r_rd_ptr];
  assign a_out_last     = (r_count != '0) & r_mem_last[r_rd_ptr];
  assign busy           = r_busy;
  assign done           = r_done;
  assign dbg_state      = r_state;
  assign dbg_fifo_count = r_count;

endmodule

// File: doc/act_buffer_reader.md
Name: act_buffer_reader

Overview:
- Read-side sequencer for the ping/pong activation buffer. It issues rd_en, k_idx and bank_sel_rd, tracks reads in the buffer's fixed-latency read pipeline, and re-times the returned vectors into a valid/ready stream for the systolic-array row feeders.
- It owns read-bank alternation. It releases each bank back to the writer once a tile has been consumed.

Parameters:
- TM, 16, activation elements per vector (INT8).
- ADDR_WIDTH, 7, buffer address width. Tile depth is at most 2^ADDR_WIDTH.
- READ_LAT, 2, buffer read latency in rd_en-active cycles.
- FIFO_DEPTH, 4, output skid FIFO entries. Must be at least READ_LAT+1 and a power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: stream one tile. Ignored unless busy=0.
- k_len  in  ADDR_WIDTH+1  vectors in the tile, sampled on start
- bank_ready  in  2  per-bank level: writer has filled bank b
- bank_release  out  2  one-cycle pulse: bank b has been consumed
- rd_en  out  1  buffer read enable
- k_idx  out  ADDR_WIDTH  buffer read address
- bank_sel_rd  out  1  buffer read bank
- a_vec  in  TM*8  buffer read data
- a_out_data  out  TM*8  vector to array
- a_out_valid  out  1  a_out_data is valid
- a_out_ready  in  1  array accepts
- a_out_last  out  1  marks the final vector of the tile, qualified by valid
- busy  out  1  a tile is in progress
- done  out  1  one-cycle pulse at tile end

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - FIFO is empty, tag pipe is cleared, cur_bank=0, state=IDLE.
  - Reset mid-tile abandons the tile with no bank_release.
- Buffer contract: the buffer's read pipeline advances only on cycles with rd_en=1. A vector read at issue cycle t appears on a_vec after READ_LAT subsequent rd_en=1 cycles.
- Tag pipe:
  - It is READ_LAT bits long and shifts only when rd_en=1. A real read inserts 1; a dummy read inserts 0.
  - When rd_en=1 and the outgoing tag is 1, a_vec is pushed into the FIFO on that same cycle.
  - rd_en=1 whenever a real read is issued or any tag bit is 1. This keeps the buffer pipeline from freezing with data in flight.
  - A dummy read re-reads the previous k_idx and bank, and its data is discarded.
- Issue rule:
  - A real read may issue when state=STREAM, issued<k_len, and fifo_count + inflight_real < FIFO_DEPTH.
  - k_idx = issued[ADDR_WIDTH-1:0], and k_idx increments by 1 per real read.
  - The FIFO therefore never overflows.
- FIFO:
  - a_out_valid = !empty.
  - Pop on valid & ready.
  - Push and pop in the same cycle is allowed, and count is unchanged.
  - a_out_last is 1 on the entry with index k_len-1.
- FSM:
  - IDLE: on start, latch len = min(k_len, 2^ADDR_WIDTH) and set busy=1.
    - If len=0, go to DONE without reading, releasing or toggling the bank.
    - Otherwise go to WAIT_BANK.
  - WAIT_BANK: bank_sel_rd=cur_bank. Go to STREAM when bank_ready[cur_bank]=1.
  - STREAM: issue reads per the issue rule. When issued==len, go to DRAIN.
  - DRAIN: wait until the tag pipe is empty, the FIFO is empty, and the last vector has been accepted.
    - Then pulse bank_release[cur_bank], toggle cur_bank, and go to DONE.
  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Timing:
  - No backpressure: first a_out_valid appears READ_LAT+1 cycles after entering STREAM.
  - Throughput is 1 vector/cycle when a_out_ready=1.
- Boundary cases:
  - a_out_ready held low: issue stops with at most FIFO_DEPTH outstanding. Flush reads complete the in-flight reads. Data order is preserved.
  - bank_ready drops during STREAM: ignored. Bank ownership is held until release.
  - start during busy: ignored.
  - start in the same cycle as done: ignored.
  - k_len = 2^ADDR_WIDTH: k_idx walks 0..2^ADDR_WIDTH-1 with no wrap issue.

Test Plan:
- Basic tile: bank_ready=01, start with k_len=8, a_out_ready=1.
  - Vectors for k_idx 0..7 from bank 0 appear in order, 1/cycle, starting READ_LAT+1 cycles after STREAM.
  - a_out_last is set on the 8th vector.
  - bank_release=01 pulses, then done pulses. The next tile uses bank 1.
- Ping/pong: bank_ready=11, two back-to-back tiles with k_len=4.
  - bank_sel_rd is 0 then 1.
  - bank_release pulses 01 then 10.
  - Data matches the per-bank patterns.
- Backpressure: k_len=16, a_out_ready toggled in a 3-low/1-high pattern.
  - All 16 vectors are delivered exactly once, in order.
  - fifo_count never exceeds 4.
  - rd_en stays high while any tag is pending.
- Bank wait: start with bank_ready=00.
  - rd_en stays 0 for 10 cycles.
  - Raising bank_ready[0] begins streaming on the next cycle.
- Edge lengths:
  - k_len=0: done 2 cycles after start, no rd_en, no release.
  - k_len=128 (ADDR_WIDTH=7): k_idx covers 0..127 and 128 vectors are delivered.
  - k_len=200: saturates to 128 vectors.
- Reset mid-tile: assert rst_n=0 after 5 vectors of 16.
  - All outputs go to 0 immediately, with no bank_release.
  - After reset, a new start reads bank 0 from k_idx 0.
